// File: rtl/conv_sched_pkg.sv
// Shared types and constants for the 1x1 convolution layer scheduler.
package conv_sched_pkg;

  localparam int PE_LANES   = 4;   // filters retired per PE finish event
  localparam int CH_ALIGN   = 16;  // input-channel granularity of the PE array
  localparam int CFG_ADDR_W = 32;  // descriptor storage width for the OFM base
  localparam int CFG_PIX_W  = 16;  // descriptor storage width for the pixel count

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RUN,
    S_DRAIN,
    S_DONE
  } sched_state_e;

  typedef struct packed {
    logic [10:0]           weight_c;
    logic [10:0]           num_filter;
    logic [CFG_PIX_W-1:0]  num_pixel;
    logic [CFG_ADDR_W-1:0] ofm_base;
  } layer_cfg_t;

  // A layer is runnable only if channels and filters fill whole PE passes
  // and there is at least one pixel to process.
  function automatic logic cfg_is_valid(input layer_cfg_t c);
    return (c.weight_c >= 11'(CH_ALIGN)) && (c.weight_c[3:0] == 4'd0) &&
           (c.num_filter >= 11'(PE_LANES)) && (c.num_filter[1:0] == 2'd0) &&
           (c.num_pixel != '0);
  endfunction

endpackage

// File: rtl/pe_finish_edge_det.sv
// Turns the level-style PE finish flags into a single-cycle event on the
// rising edge of "all lanes finished".
module pe_finish_edge_det
  import conv_sched_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic [PE_LANES-1:0] i_pe_finish,
  output logic                o_finish_evt
);

  logic [PE_LANES-1:0] r_pe_finish_prev;

  // History of the finish flags from the previous cycle.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) r_pe_finish_prev <= '0;
    else          r_pe_finish_prev <= i_pe_finish;
  end

  // Partial patterns never fire; holding all-ones fires only once.
  assign o_finish_evt = (i_pe_finish == '1) && (r_pe_finish_prev != '1);

endmodule

// File: rtl/conv1x1_layer_scheduler.sv
// Layer sequencer for the 1x1 convolution controller: accepts one layer
// descriptor, holds cal_start for the whole layer, emits one OFM write per
// completed filter group and pulses layer_done at the end.
// Optional watchdog: define SCHED_WATCHDOG_EN to abort a layer that sees no
// finish event for WDOG_LIMIT RUN cycles.
module conv1x1_layer_scheduler
  import conv_sched_pkg::*;
#(
  parameter int ADDR_W    = CFG_ADDR_W,
  parameter int PIX_W     = CFG_PIX_W,
  parameter int DRAIN_CYC = 2
`ifdef SCHED_WATCHDOG_EN
  , parameter int WDOG_LIMIT = 4096
`endif
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [10:0]       cfg_weight_c,
  input  logic [10:0]       cfg_num_filter,
  input  logic [PIX_W-1:0]  cfg_num_pixel,
  input  logic [ADDR_W-1:0] cfg_ofm_base,
  input  logic              abort,
  input  logic [3:0]        pe_finish,
  output logic              cal_start,
  output logic              ofm_wr_en,
  output logic [ADDR_W-1:0] ofm_wr_addr,
  output logic              busy,
  output logic              layer_done,
  output logic              cfg_error,
  output logic              err_timeout
);

  localparam int DRAIN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

  sched_state_e        r_state;
  layer_cfg_t          r_cfg;
  logic [8:0]          r_grp_cnt;
  logic [PIX_W-1:0]    r_pix_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic [DRAIN_W-1:0]  r_drain_cnt;
  logic                r_cfg_ready;
  logic                r_cal_start;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic                r_busy;
  logic                r_layer_done;

  logic w_finish_evt;
  logic w_handshake;
  logic w_cfg_ok;
  logic w_last_grp;
  logic w_last_pix;

  pe_finish_edge_det u_edge_det (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_pe_finish  (pe_finish),
    .o_finish_evt (w_finish_evt)
  );

  assign w_handshake = cfg_valid && r_cfg_ready;
  assign w_cfg_ok    = cfg_is_valid(r_cfg);
  assign w_last_grp  = (r_grp_cnt == (r_cfg.num_filter[10:2] - 9'd1));
  assign w_last_pix  = (r_pix_cnt == (PIX_W'(r_cfg.num_pixel) - PIX_W'(1)));

`ifdef SCHED_WATCHDOG_EN
  logic [15:0] r_wdog_cnt;
  logic        r_err_timeout;
  logic        w_wdog_hit;
  assign w_wdog_hit = (r_wdog_cnt == 16'(WDOG_LIMIT - 1));
`endif

  // Layer FSM with counters, address generation and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cfg        <= '0;
      r_grp_cnt    <= '0;
      r_pix_cnt    <= '0;
      r_addr       <= '0;
      r_drain_cnt  <= '0;
      r_cfg_ready  <= 1'b0;
      r_cal_start  <= 1'b0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_busy       <= 1'b0;
      r_layer_done <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
      r_wdog_cnt    <= '0;
      r_err_timeout <= 1'b0;
`endif
    end else begin
      r_wr_en      <= 1'b0;
      r_layer_done <= 1'b0;
`ifdef SCHED_WATCHDOG_EN
      r_err_timeout <= 1'b0;
`endif
      if (abort && (r_state != S_IDLE)) begin
        // Abort beats a coincident finish event: no write, no layer_done.
        r_state     <= S_IDLE;
        r_cfg_ready <= 1'b1;
        r_cal_start <= 1'b0;
        r_busy      <= 1'b0;
        r_grp_cnt   <= '0;
        r_pix_cnt   <= '0;
        r_drain_cnt <= '0;
`ifdef SCHED_WATCHDOG_EN
        r_wdog_cnt  <= '0;
`endif
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_cfg_ready <= !w_handshake;
            if (w_handshake) begin
              r_state <= S_CHECK;
              r_busy  <= 1'b1;
              r_cfg   <= '{weight_c:   cfg_weight_c,
                           num_filter: cfg_num_filter,
                           num_pixel:  CFG_PIX_W'(cfg_num_pixel),
                           ofm_base:   CFG_ADDR_W'(cfg_ofm_base)};
            end
          end
          S_CHECK: begin
            if (w_cfg_ok) begin
              r_state     <= S_RUN;
              r_cal_start <= 1'b1;
              r_grp_cnt   <= '0;
              r_pix_cnt   <= '0;
              r_addr      <= ADDR_W'(r_cfg.ofm_base);
`ifdef SCHED_WATCHDOG_EN
              r_wdog_cnt  <= '0;
`endif
            end else begin
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
              r_cfg_ready <= 1'b1;
            end
          end
          S_RUN: begin
            if (w_finish_evt) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_addr;
              r_addr    <= r_addr + ADDR_W'(PE_LANES);
`ifdef SCHED_WATCHDOG_EN
              r_wdog_cnt <= '0;
`endif
              if (w_last_grp) begin
                r_grp_cnt <= '0;
                r_pix_cnt <= r_pix_cnt + PIX_W'(1);
                if (w_last_pix) begin
                  r_state     <= S_DRAIN;
                  r_cal_start <= 1'b0;
                  r_drain_cnt <= '0;
                end
              end else begin
                r_grp_cnt <= r_grp_cnt + 9'd1;
              end
            end
`ifdef SCHED_WATCHDOG_EN
            else if (w_wdog_hit) begin
              r_state       <= S_IDLE;
              r_err_timeout <= 1'b1;
              r_cfg_ready   <= 1'b1;
              r_cal_start   <= 1'b0;
              r_busy        <= 1'b0;
              r_grp_cnt     <= '0;
              r_pix_cnt     <= '0;
              r_wdog_cnt    <= '0;
            end else begin
              r_wdog_cnt <= r_wdog_cnt + 16'd1;
            end
`endif
          end
          S_DRAIN: begin
            if (r_drain_cnt == DRAIN_W'(DRAIN_CYC - 1)) begin
              r_state      <= S_DONE;
              r_layer_done <= 1'b1;
            end else begin
              r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
            end
          end
          S_DONE: begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign cfg_ready   = r_cfg_ready;
  assign cal_start   = r_cal_start;
  assign ofm_wr_en   = r_wr_en;
  assign ofm_wr_addr = r_wr_addr;
  assign busy        = r_busy;
  assign layer_done  = r_layer_done;
  // Decoded from registered state and descriptor so the reject pulse lands
  // in the CHECK cycle itself, one cycle after the handshake.
  assign cfg_error   = (r_state == S_CHECK) && !w_cfg_ok;
`ifdef SCHED_WATCHDOG_EN
  assign err_timeout = r_err_timeout;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: doc/conv1x1_layer_scheduler.md
# conv1x1_layer_scheduler

Layer-level sequencer for the 1x1 convolution controller and its 4-lane PE group. It accepts one layer descriptor through a valid/ready handshake and holds `cal_start` to the controller for the whole layer. It counts PE finish events, emits one OFM write strobe with a running address per completed 4-filter group, and pulses `layer_done` when every pixel × filter group has retired.

## Interface
- `ADDR_W`, 32: OFM address width.
- `PIX_W`, 16: pixel-count width.
- `DRAIN_CYC`, 2: cycles `cal_start` is held low after the last event, before `layer_done`.
- `WDOG_LIMIT`, 4096: watchdog cycle limit (only with the macro).

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `cfg_valid` in 1: descriptor valid.
- `cfg_ready` out 1: descriptor accepted when high with `cfg_valid`.
- `cfg_weight_c` in 11: input channels.
- `cfg_num_filter` in 11: output filters.
- `cfg_num_pixel` in PIX_W: pixels in the layer.
- `cfg_ofm_base` in ADDR_W: OFM base address.
- `abort` in 1: cancel the current layer.
- `pe_finish` in 4: PE finish flags from the controller.
- `cal_start` out 1: run enable to the controller.
- `ofm_wr_en` out 1: one-cycle write strobe.
- `ofm_wr_addr` out ADDR_W: write address, valid with `ofm_wr_en`.
- `busy` out 1: high in every state except IDLE.
- `layer_done` out 1: one-cycle completion pulse.
- `cfg_error` out 1: one-cycle descriptor-rejected pulse.
- `err_timeout` out 1: one-cycle watchdog pulse (driven 0 without the macro).

## Operation
- **States:** IDLE, CHECK, RUN, DRAIN, DONE.
- **IDLE**
  - `cfg_ready`=1 only here.
  - On handshake, latch all `cfg_*` fields and go to CHECK.
- **CHECK** (1 cycle): descriptor is valid iff all of the following hold:
  - `weight_c`≥16 and `weight_c[3:0]`==0
  - `num_filter`≥4 and `num_filter[1:0]`==0
  - `num_pixel`≥1
- **CHECK outcome**
  - Invalid: `cfg_error`=1 for one cycle, return to IDLE.
  - Valid: go to RUN; clear `grp_cnt` and `pix_cnt`; `addr_r`=`ofm_base`.
- **RUN**
  - `cal_start`=1.
  - Finish event = `pe_finish`==4'hF this cycle while the registered previous `pe_finish`!=4'hF (rising edge of all-ones).
  - Partial patterns are ignored.
  - Holding 4'hF for several cycles counts as one event.
- **Per event**
  - `ofm_wr_addr`←`addr_r`, `ofm_wr_en`←1.
  - `addr_r`+=4.
  - `grp_cnt`+=1.
  - When `grp_cnt`==`num_filter`/4−1: `grp_cnt`←0 and `pix_cnt`+=1.
- **Last event** (last group of pixel `num_pixel`−1): go to DRAIN.
- **DRAIN**
  - `cal_start`=0 for `DRAIN_CYC` cycles.
  - Then DONE: `layer_done`=1 for one cycle, then IDLE.
- **Address arithmetic**
  - Pixel-major and contiguous, so no multiplier.
  - `addr_r` is ADDR_W bits and wraps modulo 2^ADDR_W.
  - `grp_cnt` is 9 bits; `pix_cnt` is PIX_W bits.
- **abort**
  - Any non-IDLE state returns to IDLE next cycle: `cal_start`=0, counters cleared, no `layer_done`.
  - If abort coincides with a finish event, abort wins and no write is issued.
- **Reset:** all outputs 0, state IDLE, counters and `pe_finish` history register 0. `cfg_ready` rises the cycle after reset deasserts.

## Timing
- Handshake at cycle T; CHECK at T+1; `cal_start`=1 from T+2 (registered).
- `ofm_wr_en`/`ofm_wr_addr` asserted the cycle after the `pe_finish` edge is sampled (1-cycle latency).
- Last event sampled at E:
  - last write at E+1;
  - `cal_start` low from E+1 through E+`DRAIN_CYC`;
  - `layer_done` at E+`DRAIN_CYC`+1;
  - `cfg_ready` at E+`DRAIN_CYC`+2.
- `cfg_*` are ignored outside IDLE and are not re-sampled mid-layer.
- An invalid descriptor's `cfg_error` pulse lands at T+1; `cfg_ready` returns at T+2.

## Configuration
- `SCHED_WATCHDOG_EN` defined:
  - 16-bit cycle counter in RUN, cleared on every finish event and on entering RUN.
  - On reaching `WDOG_LIMIT`: `err_timeout`=1 for one cycle, `cal_start`←0, return to IDLE; same cleanup as abort.
- Undefined: no counter; `err_timeout` tied 0; RUN waits indefinitely.

## Structure
- **Shared package `conv_sched_pkg`:**
  - state enum;
  - `PE_LANES`=4;
  - `CH_ALIGN`=16;
  - `layer_cfg_t` struct (`weight_c`, `num_filter`, `num_pixel`, `ofm_base`).
- **Sub-module `pe_finish_edge_det`:** registers `pe_finish`, outputs the one-cycle event.
- Everything else (FSM, counters, address, watchdog) lives in the top module.

## Test plan
- **Minimal layer:** cfg 16/4/1, base 0x100; one `pe_finish`=F pulse → one write @0x100; `layer_done` `DRAIN_CYC`+1 cycles after the event.
- **Multi-group layer:** cfg 32/8/2, base 0x0; four events → addresses 0x0, 0x4, 0x8, 0xC; `cal_start` low after the 4th event.
- **Invalid descriptor:** cfg `weight_c`=24 → `cfg_error` pulse at T+1; `cal_start` never rises; `cfg_ready` back at T+2.
- **Edge detection:** `pe_finish`=F held 5 cycles, then 4'h7 for 3 cycles → exactly one write.
- **Abort:** abort during RUN after 1 of 4 events, coincident with a finish edge → no write that cycle, no `layer_done`, `cal_start` 0 next cycle, IDLE; a new cfg restarts at its own base.
- **Watchdog (`SCHED_WATCHDOG_EN`):** `WDOG_LIMIT`=64, no events → `err_timeout` at 64 RUN cycles, then IDLE; without the macro, RUN persists for 1000 cycles.
